bin_to_bcd: RTL

BIN_TO_BCD -- requirements
Module: bin_to_bcd

---
 rtl/bin_to_bcd_pkg.sv | 30 +++
 rtl/bin_to_bcd_add3.sv | 17 +
 rtl/bin_to_bcd.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the binary-to-BCD converter:
//   - BCD_W       : width of one BCD digit
//   - state_e     : converter FSM states (IDLE / SHIFT / DONE)
//   - add3_correct: double-dabble digit correction (add 3 when digit >= 5)
// -----------------------------------------------------------------------------
package bin_to_bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A digit of 5 or more would become >= 10 after the coming doubling, so it
  // is pre-biased by 3 to make the shift produce a proper decimal carry.
  function automatic logic [BCD_W-1:0] add3_correct(input logic [BCD_W-1:0] digit);
    logic [BCD_W-1:0] res;
    if (digit >= 4'd5) begin
      res = digit + 4'd3;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin_to_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Per-digit double-dabble correction cell.
// Ports:
//   digit_i : current BCD digit
//   digit_o : digit after the add-3-if->=5 correction
// -----------------------------------------------------------------------------
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  assign digit_o = add3_correct(digit_i);

endmodule

// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes
// on both sides. One input bit is consumed per SHIFT cycle, so a conversion
// takes IN_W cycles after the accept; the result is then held in DONE until
// the consumer takes it.
// Parameters:
//   IN_W   : binary input width (4..32)
//   DIGITS : number of BCD output digits (1..10)
// Ports:
//   clock        : clock, rising edge
//   reset        : synchronous active-low reset
//   io_in_valid  : binary value offered
//   io_in_ready  : converter idle, accepts a value this cycle
//   io_in_bin    : unsigned binary value
//   io_out_valid : result available and held stable
//   io_out_ready : consumer takes the result
//   io_bcd       : packed BCD result, digit 0 (units) in [3:0]
//   io_ndigits   : significant-digit count for leading-zero blanking
//   io_overflow  : value did not fit in DIGITS decimal digits
// -----------------------------------------------------------------------------
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_in_valid,
  output logic                      io_in_ready,
  input  logic [IN_W-1:0]           io_in_bin,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [BCD_W*DIGITS-1:0]   io_bcd,
  output logic [3:0]                io_ndigits,
  output logic                      io_overflow
);

  localparam int CNT_W    = $clog2(IN_W + 1);
  localparam int BCD_BITS = BCD_W * DIGITS;

  state_e              state_q,   state_d;
  logic [IN_W-1:0]     bin_q,     bin_d;
  logic [BCD_BITS-1:0] digits_q,  digits_d;
  logic                ovf_q,     ovf_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [BCD_BITS-1:0] bcd_out_q, bcd_out_d;
  logic [3:0]          nd_out_q,  nd_out_d;
  logic                ovf_out_q, ovf_out_d;

  logic [BCD_BITS-1:0] corrected_s;
  logic [BCD_BITS-1:0] shifted_s;
  logic                carry_s;
  logic [3:0]          final_nd_s;

  // One correction cell per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (digits_q[g*BCD_W +: BCD_W]),
      .digit_o (corrected_s[g*BCD_W +: BCD_W])
    );
  end

  // Shift the corrected digits left, pulling in the next binary MSB; the bit
  // leaving the top digit is a 10^DIGITS carry that is dropped (mod 10^DIGITS).
  assign shifted_s = {corrected_s[BCD_BITS-2:0], bin_q[IN_W-1]};
  assign carry_s   = corrected_s[BCD_BITS-1];

  // Significant-digit count of the value being produced this cycle:
  // highest nonzero digit index plus one, 1 for an all-zero result.
  always_comb begin
    final_nd_s = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted_s[i*BCD_W +: BCD_W] != 4'd0) begin
        final_nd_s = 4'(i + 1);
      end else begin
        final_nd_s = final_nd_s;
      end
    end
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    bcd_out_d = bcd_out_q;
    nd_out_d  = nd_out_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      ST_IDLE: begin
        if (io_in_valid) begin
          bin_d    = io_in_bin;
          digits_d = '0;
          ovf_d    = 1'b0;
          cnt_d    = CNT_W'(IN_W);
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        digits_d = shifted_s;
        bin_d    = {bin_q[IN_W-2:0], 1'b0};
        ovf_d    = ovf_q | carry_s;
        cnt_d    = cnt_q - CNT_W'(1);
        // Last iteration: capture the finished result into the output
        // registers so they are stable for the whole DONE phase.
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_DONE;
          bcd_out_d = shifted_s;
          nd_out_d  = final_nd_s;
          ovf_out_d = ovf_q | carry_s;
        end else begin
          state_d   = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (io_out_ready) begin
          state_d   = ST_IDLE;
          bcd_out_d = '0;
          nd_out_d  = 4'd1;
          ovf_out_d = 1'b0;
        end else begin
          state_d   = ST_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bcd_out_d = '0;
        nd_out_d  = 4'd1;
        ovf_out_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_out_q <= '0;
      nd_out_q  <= 4'd1;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      bcd_out_q <= bcd_out_d;
      nd_out_q  <= nd_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign io_in_ready  = (state_q == ST_IDLE);
  assign io_out_valid = (state_q == ST_DONE);
  assign io_bcd       = bcd_out_q;
  assign io_ndigits   = nd_out_q;
  assign io_overflow  = ovf_out_q;

endmodule
